// File: rtl/hc595_scan_ctrl.sv
// hc595_scan_ctrl: scans six 7-segment digits through a 74HC595 chain, one
// 14-bit {sel, seg} frame per slot, with a tick-aligned shadow update handshake.
module hc595_scan_ctrl #(
  parameter int SCAN_CNT = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [47:0] seg_data,
  input  logic [5:0]  sel_en,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        ds,
  output logic        shcp,
  output logic        stcp,
  output logic        oe,
  output logic        busy
);
  localparam logic [19:0] LAST = 20'(SCAN_CNT - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t      state_q;
  logic [19:0] cnt_q;
  logic [1:0]  ph_q;
  logic [3:0]  bit_q;
  logic [2:0]  dig_q;
  logic        lat_q;
  logic [47:0] seg_q;
  logic [5:0]  en_q;
  logic        ds_q, shcp_q, stcp_q, oe_q, busy_q;
  logic        tick, cap;
  logic [5:0]  sel;
  logic [13:0] frame;
  assign tick = cnt_q == LAST;
  assign cap = sys_rst_n && state_q == IDLE && tick && dig_q == 3'd0 && upd_req;
  assign upd_ack = cap;
  assign sel = en_q[dig_q] ? 6'(6'd1 << dig_q) : 6'd0;
  assign frame = {sel, seg_q[{dig_q, 3'b000} +: 8]};
  assign ds = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign oe = oe_q;
  assign busy = busy_q;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ph_q <= '0;
      bit_q <= '0;
      dig_q <= '0;
      lat_q <= 1'b0;
      seg_q <= '1;
      en_q <= '0;
      ds_q <= 1'b0;
      shcp_q <= 1'b0;
      stcp_q <= 1'b0;
      oe_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 20'd1;
      case (state_q)
        IDLE: if (tick) begin
          state_q <= SHIFT;
          ph_q <= '0;
          bit_q <= '0;
          busy_q <= 1'b1;
          // a capturing tick must shift the freshly loaded digit-0 code
          ds_q <= cap ? seg_data[0] : frame[0];
          if (cap) begin
            seg_q <= seg_data;
            en_q <= sel_en;
          end
        end
        SHIFT: begin
          ph_q <= ph_q + 2'd1;
          // shcp follows bit 1 of the phase being entered (phases 2-3 high)
          shcp_q <= ph_q[0] ^ ph_q[1];
          if (ph_q == 2'd3) begin
            if (bit_q == 4'd13) begin
              state_q <= LATCH;
              lat_q <= 1'b0;
              stcp_q <= 1'b1;
            end else begin
              bit_q <= bit_q + 4'd1;
              ds_q <= frame[bit_q + 4'd1];
            end
          end
        end
        LATCH: begin
          lat_q <= 1'b1;
          if (lat_q) begin
            state_q <= IDLE;
            stcp_q <= 1'b0;
            oe_q <= 1'b0;
            busy_q <= 1'b0;
            dig_q <= dig_q == 3'd5 ? 3'd0 : dig_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/hc595_scan_ctrl.md
HC595_SCAN_CTRL -- requirements
Module: hc595_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_CNT, default 50_000: sys_clk cycles per digit slot (1 ms at 50 MHz); legal range 64..2^20-1.
REQ-002 SHALL have port sys_clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port seg_data, input, 48: six segment codes, digit k at [8k+7:8k]; active-low segments.
REQ-005 SHALL have port sel_en, input, 6: digit enable mask; bit k enables digit k.
REQ-006 SHALL have port upd_req, input, 1: level request to load seg_data/sel_en; held until upd_ack.
REQ-007 SHALL have port upd_ack, output, 1: one-cycle pulse marking capture of the display data.
REQ-008 SHALL have port ds, output, 1: 74HC595 serial data.
REQ-009 SHALL have port shcp, output, 1: 74HC595 shift clock.
REQ-010 SHALL have port stcp, output, 1: 74HC595 storage (latch) clock.
REQ-011 SHALL have port oe, output, 1: 74HC595 output enable, active-low.
REQ-012 SHALL have port busy, output, 1: high while a frame is being shifted or latched.

Function
REQ-013 SHALL use a free-running slot counter 0..SCAN_CNT-1 that wraps and emits a one-cycle tick at SCAN_CNT-1.
REQ-014 SHALL implement states IDLE, SHIFT and LATCH: IDLE->SHIFT on tick; SHIFT->LATCH after bit 13 phase 3; LATCH->IDLE after 2 cycles.
REQ-015 SHALL build each frame as 14 bits {sel[5:0], seg[7:0]} from the shadow registers and shift it LSB first (seg bit 0 first, sel bit 5 last).
REQ-016 SHALL set sel to one-hot (bit = current digit index) when that digit's shadow enable bit is 1, and to 6'b000000 otherwise; frame timing is identical either way.
REQ-017 SHALL use 4 sys_clk cycles per bit (phases 0-3): ds updates at phase 0, shcp = phase bit 1 (high in phases 2-3), so ds is stable 2 cycles before each shcp rising edge.
REQ-018 SHALL complete SHIFT in exactly 56 cycles, with shcp low on SHIFT exit.
REQ-019 SHALL drive stcp high for both LATCH cycles, with shcp low and ds held.
REQ-020 SHALL advance the digit index 0->1->...->5->0 on LATCH exit.
REQ-021 SHALL assert busy throughout SHIFT and LATCH (58 cycles per frame) and deassert it in IDLE.
REQ-022 SHALL capture seg_data and sel_en into shadow registers only in IDLE, with digit index 0, on the tick cycle and only when upd_req=1; upd_ack pulses high in that same cycle.
REQ-023 SHALL leave the shadow registers unchanged and hold upd_ack low when upd_req=0 at that point; the update latency is at most 6*SCAN_CNT cycles.
REQ-024 SHALL ignore input changes at any other time; a frame sweep is never torn.
REQ-025 SHALL hold oe high from reset until the end of the first LATCH, then drive it low permanently.
REQ-026 SHALL ignore a tick that coincides with SHIFT or LATCH; this cannot occur when SCAN_CNT >= 64.

Reset
REQ-027 SHALL, while sys_rst_n=0 at a clock edge, force ds=0, shcp=0, stcp=0, oe=1, busy=0, upd_ack=0, state IDLE, digit index 0, slot counter 0, shadow seg=8'hFF for each digit, and shadow sel_en=6'b000000.
REQ-028 SHALL, when reset is asserted mid-SHIFT or mid-LATCH, abort the frame on the next edge with no further stcp pulse; oe=1 blanks the stale 595 contents.
REQ-029 SHALL emit the first tick SCAN_CNT cycles after reset release.

Verification (SCAN_CNT=64)
REQ-030 SHALL cover: reset release, upd_req=0 -> first frame starts at cycle 64 with 14 bits = seg 8'hFF, sel 6'b000000; stcp high for 2 cycles at frame cycles 57-58; oe falls after the first latch.
REQ-031 SHALL cover: upd_req=1, seg_data digit0=8'hC0, sel_en=6'b000001 held -> upd_ack pulses once at the digit-0 tick; the serial model decodes seg=8'hC0, sel=6'b000001 for digit 0 and sel=6'b000000 for digits 1-5.
REQ-032 SHALL cover: upd_req asserted while the digit index is 3 -> no capture until the next digit-0 tick, where upd_ack pulses; digits 3-5 of the current sweep still show the old data.
REQ-033 SHALL cover: seg_data changed mid-SHIFT with no upd_req -> the shifted frame bits are unchanged.
REQ-034 SHALL cover: reset asserted at SHIFT bit 7 -> next edge gives oe=1, stcp=0, shcp=0, busy=0; after release the sequence restarts per REQ-029 with digit 0.
REQ-035 SHALL cover: over 12 frames, shcp rising edges=14 per frame, stcp pulses=1 per frame, and frame starts exactly 64 cycles apart.
